// File: rtl/uart_cmd_decoder.sv
// Purpose: frames 7-byte host commands from the UART and turns them into single register writes or reads.
// Latency: a write strobes the cycle after the 7th byte; read data returns the cycle after done or after the read timeout.
// Backpressure: none on rx (bytes arriving during execute/respond are dropped); tx holds each byte until tx_ready.
module uart_cmd_decoder #(
    parameter logic [7:0]  MAGIC        = 8'hCC,
    parameter logic [6:0]  CMD_CODE     = 7'h06,
    parameter int          IDLE_TIMEOUT = 4340,
    parameter int          RD_TIMEOUT   = 255,
    parameter logic [31:0] RD_ERR_VALUE = 32'hBAD0BAD0
) (
    input  logic        clk_25mhz,
    input  logic        core_reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  u_reg_addr,
    output logic [31:0] u_reg_wr_data,
    output logic        u_reg_wr_en,
    output logic        u_reg_rd_en,
    input  logic [31:0] u_reg_rd_data,
    input  logic        u_reg_rd_done,
    output logic        frame_err,
    output logic        rd_timeout,
    output logic        rx_overrun
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int RD_W   = $clog2(RD_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_TIMEOUT - 1);
    localparam logic [RD_W-1:0]   RD_MAX    = RD_W'(RD_TIMEOUT);

    typedef enum logic [3:0] {
        HUNT, CMD, ADDR, D0, D1, D2, D3, EXEC_WR, EXEC_RD, RESP
    } state_t;

    state_t            state, state_nxt;
    logic              is_rd;
    logic [23:0]       data_shadow;
    logic [31:0]       resp_word;
    logic [1:0]        byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [RD_W-1:0]   rd_cnt;
    logic              in_frame, idle_expired, rd_expired;
    logic              frame_err_nxt, rd_timeout_nxt, rx_overrun_nxt;

    // The idle timer counts cycles since the previous byte; a byte landing on the last allowed cycle still wins.
    assign in_frame     = state inside {CMD, ADDR, D0, D1, D2, D3};
    assign idle_expired = in_frame && !rx_valid && (idle_cnt == IDLE_LAST);
    assign rd_expired   = (rd_cnt == RD_LAST);

    assign u_reg_wr_en = (state == EXEC_WR);
    assign u_reg_rd_en = (state == EXEC_RD);
    assign tx_valid    = (state == RESP);
    assign tx_data     = resp_word[31:24];

    // State register and registered single-cycle status pulses.
    always_ff @(posedge clk_25mhz or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state      <= HUNT;
            frame_err  <= 1'b0;
            rd_timeout <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_err  <= frame_err_nxt;
            rd_timeout <= rd_timeout_nxt;
            rx_overrun <= rx_overrun_nxt;
        end
    end

    // Next-state and pulse decode; a MAGIC byte inside a frame is just another byte, never a resync.
    always_comb begin
        state_nxt      = state;
        frame_err_nxt  = 1'b0;
        rd_timeout_nxt = 1'b0;
        rx_overrun_nxt = 1'b0;
        case (state)
            HUNT: if (rx_valid && rx_data == MAGIC) state_nxt = CMD;
            CMD: begin
                if (rx_valid) begin
                    if (rx_data[6:0] != CMD_CODE) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = HUNT;
                    end else begin
                        state_nxt = ADDR;
                    end
                end else if (idle_expired) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = HUNT;
                end
            end
            ADDR, D0, D1, D2, D3: begin
                if (rx_valid) begin
                    case (state)
                        ADDR:    state_nxt = D0;
                        D0:      state_nxt = D1;
                        D1:      state_nxt = D2;
                        D2:      state_nxt = D3;
                        default: state_nxt = is_rd ? EXEC_RD : EXEC_WR;
                    endcase
                end else if (idle_expired) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = HUNT;
                end
            end
            EXEC_WR: begin
                rx_overrun_nxt = rx_valid;
                state_nxt      = HUNT;
            end
            EXEC_RD: begin
                rx_overrun_nxt = rx_valid;
                if (u_reg_rd_done) begin
                    state_nxt = RESP;
                end else if (rd_expired) begin
                    rd_timeout_nxt = 1'b1;
                    state_nxt      = RESP;
                end
            end
            RESP: begin
                rx_overrun_nxt = rx_valid;
                if (tx_ready && byte_cnt == 2'd3) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Datapath: timers, address/data capture, response shift register.
    // Write data is staged in a shadow so the bus word only changes when a complete write frame arrives.
    always_ff @(posedge clk_25mhz or negedge core_reset_n) begin
        if (!core_reset_n) begin
            idle_cnt      <= '0;
            rd_cnt        <= '0;
            is_rd         <= 1'b0;
            u_reg_addr    <= '0;
            u_reg_wr_data <= '0;
            data_shadow   <= '0;
            resp_word     <= '0;
            byte_cnt      <= '0;
        end else begin
            if (rx_valid || !in_frame) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (state != EXEC_RD) begin
                rd_cnt <= '0;
            end else if (rd_cnt != RD_MAX) begin
                rd_cnt <= rd_cnt + RD_W'(1);
            end

            if (rx_valid) begin
                case (state)
                    CMD:        is_rd <= rx_data[7];
                    ADDR:       u_reg_addr <= rx_data;
                    D0, D1, D2: if (!is_rd) data_shadow <= {data_shadow[15:0], rx_data};
                    D3:         if (!is_rd) u_reg_wr_data <= {data_shadow, rx_data};
                    default:    ;
                endcase
            end

            if (state == EXEC_RD) begin
                if (u_reg_rd_done) begin
                    resp_word <= u_reg_rd_data;
                end else if (rd_expired) begin
                    resp_word <= RD_ERR_VALUE;
                end
            end else if (state == RESP && tx_ready) begin
                resp_word <= {resp_word[23:0], 8'h00};
            end

            if (state != RESP) begin
                byte_cnt <= '0;
            end else if (tx_ready) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

    localparam int IDLE_TIMEOUT = 4340;
    localparam int RD_TIMEOUT   = 255;
    localparam logic [31:0] RD_ERR_VALUE = 32'hBAD0BAD0;

    logic        clk = 1'b0;
    logic        core_reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  u_reg_addr;
    logic [31:0] u_reg_wr_data;
    logic        u_reg_wr_en;
    logic        u_reg_rd_en;
    logic [31:0] u_reg_rd_data = 32'h0;
    logic        u_reg_rd_done = 1'b0;
    logic        frame_err, rd_timeout, rx_overrun;

    uart_cmd_decoder dut (
        .clk_25mhz     (clk),
        .core_reset_n  (core_reset_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .u_reg_addr    (u_reg_addr),
        .u_reg_wr_data (u_reg_wr_data),
        .u_reg_wr_en   (u_reg_wr_en),
        .u_reg_rd_en   (u_reg_rd_en),
        .u_reg_rd_data (u_reg_rd_data),
        .u_reg_rd_done (u_reg_rd_done),
        .frame_err     (frame_err),
        .rd_timeout    (rd_timeout),
        .rx_overrun    (rx_overrun)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] rd_val;
        int          rd_delay;   // cycles after rd_en before done; -1 = never
        int          bp;         // 1 = random tx_ready
        int          gap;        // idle cycles between bytes
        int          nb;         // bytes sent
        int          n_wr;
        int          n_tx;
        logic [31:0] exp_word;   // write data or response word
        int          n_ferr;
        int          n_rdto;
        int          rd_cycles;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus controls read by the responder processes
    int          rd_delay = 0;
    logic [31:0] rd_value = 32'h0;
    int          tx_mode  = 0;

    // observations, written only by the monitor
    logic [39:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          rd_cyc = 0, ferr_n = 0, rdto_n = 0, ovr_n = 0, unstable_n = 0;
    logic [7:0]  rd_addr_seen = 8'h0;
    logic        rd_en_prev = 1'b0, stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h0;

    // Register-bus model: answers a read after rd_delay extra cycles.
    int rd_wait = 0;
    always @(posedge clk) begin
        #1;
        if (core_reset_n && u_reg_rd_en && !u_reg_rd_done) begin
            if (rd_wait == rd_delay) begin
                u_reg_rd_done = 1'b1;
                u_reg_rd_data = rd_value;
            end else begin
                rd_wait++;
            end
        end else begin
            u_reg_rd_done = 1'b0;
            if (!u_reg_rd_en) rd_wait = 0;
        end
    end

    // Transmitter model.
    always @(posedge clk) begin
        #1;
        tx_ready = (tx_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!core_reset_n) begin
            stall_prev <= 1'b0;
            rd_en_prev <= 1'b0;
        end else begin
            if (u_reg_wr_en) wr_q.push_back({u_reg_addr, u_reg_wr_data});
            if (u_reg_rd_en) rd_cyc <= rd_cyc + 1;
            if (u_reg_rd_en && !rd_en_prev) rd_addr_seen <= u_reg_addr;
            if (frame_err)  ferr_n <= ferr_n + 1;
            if (rd_timeout) rdto_n <= rdto_n + 1;
            if (rx_overrun) ovr_n  <= ovr_n + 1;
            if (tx_valid && stall_prev && tx_data != stall_data) unstable_n <= unstable_n + 1;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            stall_prev <= tx_valid && !tx_ready;
            stall_data <= tx_data;
            rd_en_prev <= u_reg_rd_en;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[8], input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            tick(1);
            rx_valid = 1'b0;
            if (i < n - 1) tick(gap);
        end
    endtask

    // Reference model: expected outcome of one command from the protocol rules alone.
    function automatic vec_t model(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                                   input logic [31:0] rd_val, input int dly, input int bp, input int gap);
        vec_t v;
        bit   ok;
        v = '{cmd, addr, data, rd_val, dly, bp, gap, 7, 0, 0, 32'h0, 0, 0, 0};
        if (cmd[6:0] != 7'h06) begin
            v.nb     = 2;
            v.n_ferr = 1;
        end else if (cmd[7]) begin
            ok          = (dly >= 0) && (dly < RD_TIMEOUT);
            v.n_tx      = 4;
            v.exp_word  = ok ? rd_val : RD_ERR_VALUE;
            v.n_rdto    = ok ? 0 : 1;
            v.rd_cycles = ok ? dly + 1 : RD_TIMEOUT;
        end else begin
            v.n_wr     = 1;
            v.exp_word = data;
        end
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        logic [7:0] b[8];
        int wb, tb, rb, fb, tob, ob, ub;
        b[0] = 8'hCC; b[1] = v.cmd; b[2] = v.addr;
        b[3] = v.data[31:24]; b[4] = v.data[23:16]; b[5] = v.data[15:8]; b[6] = v.data[7:0];
        b[7] = 8'h00;
        rd_delay = v.rd_delay;
        rd_value = v.rd_val;
        tx_mode  = v.bp;
        wb = wr_q.size(); tb = tx_q.size(); rb = rd_cyc;
        fb = ferr_n; tob = rdto_n; ob = ovr_n; ub = unstable_n;
        send_bytes(b, v.nb, v.gap);
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if (i >= 300 && !tx_valid) break;
        end
        check("wr_count", wr_q.size() - wb, v.n_wr);
        if (v.n_wr > 0 && wr_q.size() > wb) check("wr_addr_data", wr_q[wb], {v.addr, v.exp_word});
        check("rd_en_cycles", rd_cyc - rb, v.rd_cycles);
        if (v.n_tx > 0) check("rd_addr", rd_addr_seen, v.addr);
        check("tx_count", tx_q.size() - tb, v.n_tx);
        for (int k = 0; k < v.n_tx && tb + k < tx_q.size(); k++)
            check("tx_byte", tx_q[tb + k], v.exp_word[31 - 8 * k -: 8]);
        check("frame_err_count", ferr_n - fb, v.n_ferr);
        check("rd_timeout_count", rdto_n - tob, v.n_rdto);
        check("overrun_count", ovr_n - ob, 0);
        check("tx_stable", unstable_n - ub, 0);
        check("tx_idle_after", tx_valid, 0);
    endtask

    function automatic logic [63:0] all_outs();
        return {10'h0, tx_data, tx_valid, u_reg_addr, u_reg_wr_data, u_reg_wr_en, u_reg_rd_en,
                frame_err, rd_timeout, rx_overrun};
    endfunction

    vec_t tbl[10];

    initial begin
        logic [7:0] b[8];
        int wb, tb, fb, ob;
        logic [7:0] c;
        int r, dly;

        tbl[0] = '{8'h06, 8'hA2, 32'hDEADDEAD, 32'h0,        0,  0, 2169, 7, 1, 0, 32'hDEADDEAD, 0, 0, 0};
        tbl[1] = '{8'h86, 8'hA2, 32'hDEADDEAD, 32'hAAAADDDD, 1,  0, 0,    7, 0, 4, 32'hAAAADDDD, 0, 0, 2};
        tbl[2] = '{8'h86, 8'h3C, 32'h0,        32'h55555555, -1, 1, 0,    7, 0, 4, 32'hBAD0BAD0, 0, 1, 255};
        tbl[3] = '{8'h86, 8'h40, 32'h0,        32'h12345678, 254, 0, 1,   7, 0, 4, 32'h12345678, 0, 0, 255};
        tbl[4] = '{8'h86, 8'h41, 32'h0,        32'h87654321, 255, 1, 0,   7, 0, 4, 32'hBAD0BAD0, 0, 1, 255};
        tbl[5] = '{8'hCC, 8'h00, 32'h0,        32'h0,        0,  0, 0,    2, 0, 0, 32'h0,        1, 0, 0};
        tbl[6] = '{8'h07, 8'h00, 32'h0,        32'h0,        0,  0, 1,    2, 0, 0, 32'h0,        1, 0, 0};
        tbl[7] = '{8'h87, 8'h00, 32'h0,        32'h0,        0,  0, 0,    2, 0, 0, 32'h0,        1, 0, 0};
        tbl[8] = '{8'h06, 8'h00, 32'hCC06CC06, 32'h0,        0,  0, 0,    7, 1, 0, 32'hCC06CC06, 0, 0, 0};
        tbl[9] = '{8'h86, 8'hFF, 32'hCCCCCCCC, 32'h00FF00FF, 0,  1, 2,    7, 0, 4, 32'h00FF00FF, 0, 0, 1};

        core_reset_n = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #1;
        check("reset_outputs", all_outs(), 0);
        tick(3);
        core_reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < 10; i++) apply_vec(tbl[i]);

        // Garbage, then a bad command byte, then a normal write.
        b = '{8'h55, 8'h00, 8'hFF, 8'hCC, 8'h07, 8'h00, 8'h00, 8'h00};
        fb = ferr_n; ob = ovr_n; wb = wr_q.size();
        send_bytes(b, 5, 1);
        tick(20);
        check("garbage_ferr", ferr_n - fb, 1);
        check("garbage_no_overrun", ovr_n - ob, 0);
        check("garbage_no_write", wr_q.size() - wb, 0);
        apply_vec(model(8'h06, 8'h5A, 32'h01234567, 32'h0, 0, 0, 0));

        // Inter-byte silence inside a frame.
        b = '{8'hCC, 8'h06, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        fb = ferr_n;
        send_bytes(b, 3, 0);
        tick(IDLE_TIMEOUT - 2);
        check("idle_no_early_ferr", ferr_n - fb, 0);
        tick(10);
        check("idle_timeout_ferr", ferr_n - fb, 1);
        apply_vec(model(8'h06, 8'h77, 32'hFEEDF00D, 32'h0, 0, 0, 0));
        // Byte spacing at the maximum allowed gap must not time out.
        apply_vec(model(8'h06, 8'h78, 32'h0BADCAFE, 32'h0, 0, 0, IDLE_TIMEOUT - 1));

        // Byte right behind a write frame is dropped, even if it looks like MAGIC.
        b = '{8'hCC, 8'h06, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCC};
        ob = ovr_n; wb = wr_q.size(); fb = ferr_n;
        send_bytes(b, 8, 0);
        tick(3);
        b = '{8'h06, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(b, 6, 0);
        tick(10);
        check("overrun_pulse", ovr_n - ob, 1);
        check("overrun_wr_count", wr_q.size() - wb, 1);
        if (wr_q.size() > wb) check("overrun_wr_word", wr_q[wb], {8'h11, 32'h01020304});

        // Reset during D1 aborts the frame.
        b = '{8'hCC, 8'h06, 8'hA2, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
        wb = wr_q.size();
        send_bytes(b, 4, 0);
        tick(2);
        core_reset_n = 1'b0;
        #1;
        check("reset_d1_outputs", all_outs(), 0);
        tick(2);
        core_reset_n = 1'b1;
        tick(20);
        check("reset_d1_no_write", wr_q.size() - wb, 0);
        apply_vec(model(8'h06, 8'hA2, 32'hDEADBEEF, 32'h0, 0, 0, 0));

        // Reset while the second response byte is on the wire.
        b = '{8'hCC, 8'h86, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_delay = 0; rd_value = 32'h11223344; tx_mode = 0;
        tb = tx_q.size();
        send_bytes(b, 7, 0);
        for (int i = 0; i < 300 && tx_q.size() - tb < 1; i++) tick(1);
        check("resp_first_byte_seen", tx_q.size() - tb, 1);
        check("resp_byte2_on_wire", {tx_valid, tx_data}, {1'b1, 8'h22});
        core_reset_n = 1'b0;
        #1;
        check("reset_resp_outputs", all_outs(), 0);
        tick(2);
        core_reset_n = 1'b1;
        tick(10);
        check("reset_resp_no_more_tx", tx_q.size() - tb, 1);
        apply_vec(model(8'h06, 8'hC3, 32'hA5A55A5A, 32'h0, 0, 0, 0));

        // Randomised commands against the model.
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0) c = 8'h06;
            else if (r == 1) c = 8'h86;
            else begin
                c = 8'($urandom);
                while (c[6:0] == 7'h06) c = 8'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r == 0) dly = -1;
            else if (r < 4) dly = $urandom_range(RD_TIMEOUT - 3, RD_TIMEOUT + 3);
            else dly = $urandom_range(0, 6);
            apply_vec(model(c, 8'($urandom), $urandom, $urandom, dly,
                            int'($urandom_range(0, 1)), int'($urandom_range(0, 3))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder between the UART receiver and the debug register bus. Consumes received bytes, frames 7-byte host commands (magic 0xCC, command, address, four data bytes MSB first), and issues single register writes or reads. Read results are returned as four bytes to the UART transmitter. Framing, inter-byte timeout and read-timeout errors are flagged on single-cycle status pulses.

## Interface
- MAGIC, 8'hCC, frame start byte
- CMD_CODE, 7'h06, required value of command bits [6:0]
- IDLE_TIMEOUT, 4340, maximum cycles between bytes inside a frame (~2 byte times at 115200 baud, 25 MHz)
- RD_TIMEOUT, 255, maximum cycles waiting for u_reg_rd_done
- RD_ERR_VALUE, 32'hBAD0BAD0, word returned when a read times out

- clk_25mhz  in  1  system clock
- core_reset_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid, held until accepted
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready
- u_reg_addr  out  8  register address
- u_reg_wr_data  out  32  write data
- u_reg_wr_en  out  1  one-cycle write strobe
- u_reg_rd_en  out  1  read request, level held until done or timeout
- u_reg_rd_data  in  32  read data, valid while u_reg_rd_done high
- u_reg_rd_done  in  1  read complete
- frame_err  out  1  one-cycle pulse: bad command byte or inter-byte timeout
- rd_timeout  out  1  one-cycle pulse: read not completed within RD_TIMEOUT
- rx_overrun  out  1  one-cycle pulse: byte dropped while executing or responding

## Operation
- States: HUNT, CMD, ADDR, D0, D1, D2, D3, EXEC_WR, EXEC_RD, RESP.
- HUNT: a byte equal to MAGIC moves to CMD; any other byte is silently discarded.
- CMD: bit7 = 1 selects read, 0 selects write; bits [6:0] != CMD_CODE -> frame_err pulse, go to HUNT. A byte that is MAGIC is also rejected as a bad command; no resync within the frame.
- ADDR: latch u_reg_addr. D0..D3: shift into the data register in the order [31:24], [23:16], [15:8], [7:0].
- Read frames carry four data bytes as well; their values are ignored.
- After D3: write -> EXEC_WR; read -> EXEC_RD.
- EXEC_WR: u_reg_wr_en high for exactly one cycle with addr and data stable, then HUNT.
- EXEC_RD: u_reg_rd_en high; on the first cycle u_reg_rd_done is sampled high, capture u_reg_rd_data and go to RESP. If RD_TIMEOUT cycles elapse without done, load RD_ERR_VALUE, pulse rd_timeout, go to RESP.
- RESP: emit four bytes, [31:24] first; advance on each tx_valid && tx_ready; after the 4th handshake, tx_valid drops and state returns to HUNT.
- Inter-byte timer: in CMD..D3, counts cycles since the last byte; at IDLE_TIMEOUT, pulse frame_err and go to HUNT. Cleared by each rx_valid.
- rx_valid in EXEC_WR, EXEC_RD or RESP: byte dropped, rx_overrun pulse.
- u_reg_addr and u_reg_wr_data hold their last value between frames.

## Timing
- Reset (async assert, sync release): state HUNT; all outputs 0, including tx_data, u_reg_addr, u_reg_wr_data and all strobes. Timers are cleared.
- Byte accepted in cycle N updates state at N+1. The 7th byte at N gives u_reg_wr_en or the first u_reg_rd_en cycle at N+1.
- Write: HUNT at N+2; a byte arriving at N+1 is an overrun.
- Read: done sampled at cycle M -> rd_en low at M+1, tx_valid high at M+1 with byte [31:24].
- tx_data is stable while tx_valid && !tx_ready; there are no gaps mandated between bytes.
- Timeout counters compare with ==, are sized to hold the parameter, and do not wrap.
- A done arriving in the same cycle the read timeout expires counts as success.
- Reset mid-frame or mid-response aborts immediately; no partial bus access completes.

## Test plan
- Write frame CC 06 A2 DE AD DE AD at one byte per 2170 cycles -> single u_reg_wr_en pulse, u_reg_addr 0xA2, u_reg_wr_data 0xDEADDEAD, no tx_valid.
- Read frame CC 86 A2 DE AD DE AD; bus returns 0xAAAADDDD with done 1 cycle after rd_en -> tx bytes AA, AA, DD, DD in order; rd_en high exactly 2 cycles.
- Leading garbage 55 00 FF then CC 07 ... -> garbage ignored with no pulses; frame_err on the 07 byte; a following valid write frame executes normally.
- CC 06 A2 then silence for IDLE_TIMEOUT cycles -> frame_err pulse, state HUNT; the next full frame executes.
- Read with done never asserted -> rd_en high for RD_TIMEOUT cycles, rd_timeout pulse, tx bytes BA, D0, BA, D0. Randomise tx_ready with 50% backpressure: byte order preserved and tx_data stable while stalled.
- Assert core_reset_n low during D1 and again during RESP byte 2 -> all outputs 0 immediately; after release, a full write frame executes correctly.
